nway_trace_request_tracker: RTL and testbench
=============================================

# nway_trace_request_tracker

Tracks in-flight data-memory requests between the trace repository and the n-way cache. Each request carries the trace index of its instruction. The block records the request in a `cache_tracker_t` slot and dispatches requests to the cache in allocation order. When the cache responds, the block matches the response by address and emits an `active_set_entry` (trace index, address, hit/miss) to the trace repository's active set. It implements the MAKE_REQUEST → WAIT_FOR_PROCESSING → REQUEST_RETIRED lifecycle per slot.

## Interface
- `TRACKER_DEPTH`, 4: number of tracker slots; power of two, ≥2.
- `ADDR_W`, `DATA_ADDR_WIDTH`: memory address width.
- `IDX_W`, `$clog2(TRACE_ENTRIES)` (17): trace index width.

- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: a new request is offered by the trace repository.
- `req_ready` out 1: the slot at the write pointer is free.
- `req_addr` in ADDR_W: request address.
- `req_trace_index` in IDX_W: trace index of the request.
- `cache_req_valid` out 1: the oldest undispatched entry is offered to the cache.
- `cache_req_ready` in 1: the cache accepts the offered request.
- `cache_req_addr` out ADDR_W: address of the dispatched entry.
- `cache_resp_valid` in 1: the cache reports completion of a request.
- `cache_resp_ready` out 1: equals `!as_valid || as_ready`.
- `cache_resp_addr` in ADDR_W: address of the completed request.
- `cache_resp_hit` in 1: 1 = hit, 0 = miss.
- `as_valid` out 1: an active-set entry is presented.
- `as_ready` in 1: the active set consumes the entry.
- `as_entry` out `$bits(active_set_entry)`: packed {trace_index, mem_addr, trace_hit_miss_flag}.
- `occupancy` out `$clog2(TRACKER_DEPTH+1)`: number of occupied slots.
- `unmatched_resp` out 1: sticky error flag.

## Operation
- **Storage:** `TRACKER_DEPTH` × `cache_tracker_t`, plus two pointers of `$clog2(TRACKER_DEPTH)` bits each: `wr_ptr` and `disp_ptr`. Both pointers wrap modulo DEPTH.
- **Slot states:**
  - FREE: occupied=0.
  - PENDING: occupied=1, processing=0 (MAKE_REQUEST).
  - IN_CACHE: occupied=1, processing=1 (WAIT_FOR_PROCESSING).
  - Retirement (REQUEST_RETIRED) returns the slot to FREE.
- **Allocate:**
  - `req_ready = !slot[wr_ptr].occupied`.
  - On `req_valid && req_ready`: the slot becomes PENDING with addr/index from the request, and `wr_ptr++`.
  - Allocation stalls if the slot at `wr_ptr` is still held, even when other slots are free.
- **Dispatch:**
  - `cache_req_valid = slot[disp_ptr]` is PENDING.
  - On handshake: the slot becomes IN_CACHE and `disp_ptr++`.
- **Retire:** on `cache_resp_valid && cache_resp_ready`:
  - Select the oldest IN_CACHE slot whose mem_addr equals `cache_resp_addr`. "Oldest" means the first match scanning circularly from `wr_ptr` upward.
  - That slot becomes FREE.
  - `as_entry` is loaded with {slot.trace_index, slot.mem_addr, cache_resp_hit}, and `as_valid` is set.
- **No match:** the response is consumed and dropped, and `unmatched_resp` is set. It is cleared only by reset.
- **Output register:** `as_valid` is cleared on `as_valid && as_ready` unless a new retirement loads the register in the same cycle.
- **Simultaneous events:** allocate, dispatch and retire may occur in one cycle and all take effect.
  - A slot dispatched this cycle cannot match a response in the same cycle; matching uses registered state.
  - A slot retired this cycle is reallocatable from the next cycle.
- **Occupancy:** `occupancy` is a registered count, updated by +1 on allocate and −1 on retire in the same cycle; the net change is applied.
- **Reset:** asynchronous reset at any time, including mid-operation, sets:
  - all slots FREE;
  - both pointers to 0;
  - `as_valid`=0, `as_entry`=0, `occupancy`=0, `unmatched_resp`=0.
- **Derived outputs after reset:** `req_ready`=1, `cache_req_valid`=0, `cache_resp_ready`=1. In-flight cache responses are discarded.

## Timing
- Allocate to `cache_req_valid`: 1 cycle. The request is accepted at edge N and `cache_req_valid` is high after edge N.
- Response handshake to `as_valid`: 1 cycle (registered).
- `req_ready`, `cache_req_valid`, `cache_req_addr` and `cache_resp_ready` are combinational from registered state plus `as_valid`/`as_ready`. There is no combinational path from `req_valid` or `cache_resp_valid`.
- Throughput is one allocate, one dispatch and one retire per cycle.

## Configuration
- `NWAY_TRACKER_STATS_EN` defined:
  - Adds outputs `hit_count` out 32 and `miss_count` out 32.
  - Each increments on a matched retirement according to `cache_resp_hit`, saturating at 0xFFFF_FFFF.
  - Both reset to 0.
- `NWAY_TRACKER_STATS_EN` undefined: these ports and counters do not exist.

## Test plan
- **Reset and single hit:**
  - Stimulus: reset, then req addr=0x100, idx=5. Cache accepts the request, then responds addr=0x100, hit=1.
  - Required: `as_entry`={5, 0x100, 1}; `occupancy` goes 0→1→0.
- **Fill:** 4 requests with no responses.
  - Required: `req_ready`=0 after the 4th; `occupancy`=4; `cache_req_addr` is presented in allocation order.
- **Out-of-order retire:** the 4 above, responses in order 3,1,4,2.
  - Required: 4 `as_entry` emissions with the matching indices.
  - Required: `req_ready` stays 0 until slot 0 (request 1) frees.
- **Duplicate address:** idx 7 and idx 9 both at 0x200; one response for 0x200, hit=0.
  - Required: `as_entry` idx=7, flag=0; idx 9 stays IN_CACHE.
- **Backpressure:** `as_ready`=0 while two responses arrive.
  - Required: `cache_resp_ready`=0 after the first; the second is retired only after `as_ready`=1.
- **Unmatched response and reset:** response addr=0xDEAD with no entry.
  - Required: `unmatched_resp`=1, no `as_valid`.
  - Then assert `rst_n`=0 mid-flight. Required: all outputs at reset values immediately.

Source files
------------

// File: rtl/nway_trace_request_tracker.sv
// In-flight data-memory request tracker between the trace repository and the n-way cache.
// Optional hit/miss statistics counters are enabled by defining NWAY_TRACKER_STATS_EN.
module nway_trace_request_tracker #(
    parameter int TRACKER_DEPTH = 4,
    parameter int ADDR_W        = 32,
    parameter int IDX_W         = 17
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [ADDR_W-1:0]                  req_addr,
    input  logic [IDX_W-1:0]                   req_trace_index,
    output logic                               cache_req_valid,
    input  logic                               cache_req_ready,
    output logic [ADDR_W-1:0]                  cache_req_addr,
    input  logic                               cache_resp_valid,
    output logic                               cache_resp_ready,
    input  logic [ADDR_W-1:0]                  cache_resp_addr,
    input  logic                               cache_resp_hit,
    output logic                               as_valid,
    input  logic                               as_ready,
    output logic [IDX_W+ADDR_W:0]              as_entry,
    output logic [$clog2(TRACKER_DEPTH+1)-1:0] occupancy,
    output logic                               unmatched_resp
`ifdef NWAY_TRACKER_STATS_EN
    ,
    output logic [31:0]                        hit_count,
    output logic [31:0]                        miss_count
`endif
);

    localparam int PTR_W = $clog2(TRACKER_DEPTH);
    localparam int OCC_W = $clog2(TRACKER_DEPTH + 1);

    typedef struct packed {
        logic              occupied;
        logic              processing;
        logic [IDX_W-1:0]  trace_index;
        logic [ADDR_W-1:0] mem_addr;
    } cache_tracker_t;

    typedef struct packed {
        logic [IDX_W-1:0]  trace_index;
        logic [ADDR_W-1:0] mem_addr;
        logic              trace_hit_miss_flag;
    } active_set_entry;

    cache_tracker_t        slot_reg [TRACKER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      disp_ptr_reg;
    logic [OCC_W-1:0]      occupancy_reg;
    logic                  as_valid_reg;
    active_set_entry       as_entry_reg;
    logic                  unmatched_reg;

    logic [TRACKER_DEPTH-1:0] match_vec;
    logic                     match_found;
    logic [PTR_W-1:0]         match_sel;
    logic [PTR_W-1:0]         scan_idx;
    logic                     alloc_fire;
    logic                     disp_fire;
    logic                     resp_fire;
    logic                     retire_fire;

    assign req_ready        = !slot_reg[wr_ptr_reg].occupied;
    assign cache_req_valid  = slot_reg[disp_ptr_reg].occupied && !slot_reg[disp_ptr_reg].processing;
    assign cache_req_addr   = slot_reg[disp_ptr_reg].mem_addr;
    assign cache_resp_ready = !as_valid_reg || as_ready;

    assign alloc_fire  = req_valid && req_ready;
    assign disp_fire   = cache_req_valid && cache_req_ready;
    assign resp_fire   = cache_resp_valid && cache_resp_ready;
    assign retire_fire = resp_fire && match_found;

    // Only slots already in the cache as of the last edge may match a response.
    generate
        for (genvar gi = 0; gi < TRACKER_DEPTH; gi++) begin : g_match
            assign match_vec[gi] = slot_reg[gi].occupied && slot_reg[gi].processing &&
                                   (slot_reg[gi].mem_addr == cache_resp_addr);
        end
    endgenerate

    // The slot at wr_ptr is the oldest allocation, so scanning upward from it finds the oldest match.
    always_comb begin
        match_found = 1'b0;
        match_sel   = '0;
        scan_idx    = '0;
        for (int i = 0; i < TRACKER_DEPTH; i++) begin
            scan_idx = wr_ptr_reg + PTR_W'(i);
            if (!match_found && match_vec[scan_idx]) begin
                match_found = 1'b1;
                match_sel   = scan_idx;
            end
        end
    end

    // Allocate, dispatch and retire always target slots in different states, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TRACKER_DEPTH; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TRACKER_DEPTH; i++) begin
                if (alloc_fire && (wr_ptr_reg == PTR_W'(i))) begin
                    slot_reg[i].occupied    <= 1'b1;
                    slot_reg[i].processing  <= 1'b0;
                    slot_reg[i].trace_index <= req_trace_index;
                    slot_reg[i].mem_addr    <= req_addr;
                end else if (disp_fire && (disp_ptr_reg == PTR_W'(i))) begin
                    slot_reg[i].processing  <= 1'b1;
                end else if (retire_fire && (match_sel == PTR_W'(i))) begin
                    slot_reg[i].occupied    <= 1'b0;
                    slot_reg[i].processing  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            disp_ptr_reg  <= '0;
            occupancy_reg <= '0;
            as_valid_reg  <= 1'b0;
            as_entry_reg  <= '0;
            unmatched_reg <= 1'b0;
        end else begin
            if (alloc_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (disp_fire) begin
                disp_ptr_reg <= disp_ptr_reg + PTR_W'(1);
            end
            case ({alloc_fire, retire_fire})
                2'b10:   occupancy_reg <= occupancy_reg + OCC_W'(1);
                2'b01:   occupancy_reg <= occupancy_reg - OCC_W'(1);
                default: occupancy_reg <= occupancy_reg;
            endcase
            if (retire_fire) begin
                as_valid_reg                     <= 1'b1;
                as_entry_reg.trace_index         <= slot_reg[match_sel].trace_index;
                as_entry_reg.mem_addr            <= slot_reg[match_sel].mem_addr;
                as_entry_reg.trace_hit_miss_flag <= cache_resp_hit;
            end else if (as_valid_reg && as_ready) begin
                as_valid_reg <= 1'b0;
            end
            if (resp_fire && !match_found) begin
                unmatched_reg <= 1'b1;
            end
        end
    end

`ifdef NWAY_TRACKER_STATS_EN
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else if (retire_fire) begin
            if (cache_resp_hit && (hit_count_reg != 32'hFFFF_FFFF)) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (!cache_resp_hit && (miss_count_reg != 32'hFFFF_FFFF)) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

    assign as_valid       = as_valid_reg;
    assign as_entry       = as_entry_reg;
    assign occupancy      = occupancy_reg;
    assign unmatched_resp = unmatched_reg;

endmodule

// File: tb/tb_nway_trace_request_tracker.sv
// Bench for nway_trace_request_tracker: directed vector table, corner-case sequences,
// and a randomized run against an allocation-ordered reference model.
module tb_nway_trace_request_tracker;

    localparam int D  = 4;
    localparam int AW = 32;
    localparam int IW = 17;
    localparam int EW = IW + AW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [IW-1:0] req_trace_index;
    logic          cache_req_valid;
    logic          cache_req_ready;
    logic [AW-1:0] cache_req_addr;
    logic          cache_resp_valid;
    logic          cache_resp_ready;
    logic [AW-1:0] cache_resp_addr;
    logic          cache_resp_hit;
    logic          as_valid;
    logic          as_ready;
    logic [EW-1:0] as_entry;
    logic [2:0]    occupancy;
    logic          unmatched_resp;

    always #5 clk = ~clk;

    nway_trace_request_tracker #(.TRACKER_DEPTH(D), .ADDR_W(AW), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_trace_index(req_trace_index),
        .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
        .cache_req_addr(cache_req_addr),
        .cache_resp_valid(cache_resp_valid), .cache_resp_ready(cache_resp_ready),
        .cache_resp_addr(cache_resp_addr), .cache_resp_hit(cache_resp_hit),
        .as_valid(as_valid), .as_ready(as_ready), .as_entry(as_entry),
        .occupancy(occupancy), .unmatched_resp(unmatched_resp)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input int idx, input logic [AW-1:0] addr, input logic hit);
        return {IW'(idx), addr, hit};
    endfunction

    task automatic cyc(input logic rv, input logic [AW-1:0] ra, input int ri, input logic crr,
                       input logic rsv, input logic [AW-1:0] rsa, input logic rsh, input logic asr);
        @(negedge clk);
        req_valid        = rv;
        req_addr         = ra;
        req_trace_index  = IW'(ri);
        cache_req_ready  = crr;
        cache_resp_valid = rsv;
        cache_resp_addr  = rsa;
        cache_resp_hit   = rsh;
        as_ready         = asr;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 0; req_addr = 0; req_trace_index = 0; cache_req_ready = 0;
        cache_resp_valid = 0; cache_resp_addr = 0; cache_resp_hit = 0; as_ready = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic rv; logic [AW-1:0] ra; int ri; logic crr;
        logic rsv; logic [AW-1:0] rsa; logic rsh;
        logic e_rr; logic e_cv; logic [AW-1:0] e_ca; logic e_av; logic [EW-1:0] e_ae; logic [2:0] e_occ;
    } vec_t;

    vec_t vecs [11];

    // Reference model: live requests in allocation order, tagged by allocation sequence number.
    typedef struct {
        int seq; logic [AW-1:0] addr; logic [IW-1:0] idx; bit disp;
    } rec_t;

    rec_t          q [$];
    rec_t          tmp;
    int            n_alloc, n_disp;
    bit            m_av, m_unm, m_rr, m_cv, m_rsr, m_found;
    logic [AW-1:0] m_ca;
    logic [EW-1:0] m_ae;
    int            disp_list [$];
    int            order [4];

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_addr = 0; req_trace_index = 0; cache_req_ready = 0;
        cache_resp_valid = 0; cache_resp_addr = 0; cache_resp_hit = 0; as_ready = 1;

        //          rv  ra      ri crr rsv rsa     rsh  rr cv  ca      av  ae                     occ
        vecs[0]  = '{1, 'h100, 5, 0,  0,  0,     0,   1, 1, 'h100, 0,  0,                     1};
        vecs[1]  = '{0, 0,     0, 1,  0,  0,     0,   1, 0, 0,     0,  0,                     1};
        vecs[2]  = '{0, 0,     0, 0,  1,  'h100, 1,   1, 0, 0,     1,  ent(5, 'h100, 1),      0};
        vecs[3]  = '{0, 0,     0, 0,  0,  0,     0,   1, 0, 0,     0,  0,                     0};
        vecs[4]  = '{1, 'h200, 7, 0,  0,  0,     0,   1, 1, 'h200, 0,  0,                     1};
        vecs[5]  = '{1, 'h200, 9, 1,  0,  0,     0,   1, 1, 'h200, 0,  0,                     2};
        vecs[6]  = '{0, 0,     0, 1,  0,  0,     0,   1, 0, 0,     0,  0,                     2};
        vecs[7]  = '{0, 0,     0, 0,  1,  'h200, 0,   1, 0, 0,     1,  ent(7, 'h200, 0),      1};
        vecs[8]  = '{0, 0,     0, 0,  0,  0,     0,   1, 0, 0,     0,  0,                     1};
        vecs[9]  = '{0, 0,     0, 0,  1,  'h200, 1,   1, 0, 0,     1,  ent(9, 'h200, 1),      0};
        vecs[10] = '{0, 0,     0, 0,  0,  0,     0,   1, 0, 0,     0,  0,                     0};

        repeat (2) @(negedge clk);
        #1;
        check("reset.as_valid", 64'(as_valid), 0);
        check("reset.occupancy", 64'(occupancy), 0);
        rst_n = 1'b1;
        #1;
        check("reset.outputs", {req_ready, cache_req_valid, cache_resp_ready, as_valid, unmatched_resp},
              5'b10100);
        check("reset.as_entry", 64'(as_entry), 0);

        // Single hit and duplicate-address table.
        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].rv, vecs[i].ra, vecs[i].ri, vecs[i].crr, vecs[i].rsv, vecs[i].rsa, vecs[i].rsh, 1'b1);
            check($sformatf("vec%0d.req_ready", i), 64'(req_ready), 64'(vecs[i].e_rr));
            check($sformatf("vec%0d.cache_req_valid", i), 64'(cache_req_valid), 64'(vecs[i].e_cv));
            if (vecs[i].e_cv)
                check($sformatf("vec%0d.cache_req_addr", i), 64'(cache_req_addr), 64'(vecs[i].e_ca));
            check($sformatf("vec%0d.as_valid", i), 64'(as_valid), 64'(vecs[i].e_av));
            if (vecs[i].e_av)
                check($sformatf("vec%0d.as_entry", i), 64'(as_entry), 64'(vecs[i].e_ae));
            check($sformatf("vec%0d.occupancy", i), 64'(occupancy), 64'(vecs[i].e_occ));
        end

        // Fill, then out-of-order retirement 3,1,4,2.
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            cyc(1, AW'(32'h10 * (k + 1)), k + 1, 0, 0, 0, 0, 1);
            check($sformatf("fill%0d.occupancy", k), 64'(occupancy), 64'(k + 1));
        end
        check("fill.req_ready", 64'(req_ready), 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fill.disp%0d.valid", k), 64'(cache_req_valid), 1);
            check($sformatf("fill.disp%0d.addr", k), 64'(cache_req_addr), 64'(32'h10 * (k + 1)));
            cyc(0, 0, 0, 1, 0, 0, 0, 1);
        end
        check("fill.dispatched_all", 64'(cache_req_valid), 0);
        order = '{3, 1, 4, 2};
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 1, AW'(32'h10 * order[k]), k[0], 1);
            check($sformatf("ooo%0d.as_valid", k), 64'(as_valid), 1);
            check($sformatf("ooo%0d.as_entry", k), 64'(as_entry), 64'(ent(order[k], AW'(32'h10 * order[k]), k[0])));
            check($sformatf("ooo%0d.req_ready", k), 64'(req_ready), 64'(k >= 1));
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        check("ooo.occupancy", 64'(occupancy), 0);
        check("ooo.as_valid_clear", 64'(as_valid), 0);

        // Backpressure on the active-set output.
        cyc(1, 'h50, 10, 0, 0, 0, 0, 1);
        cyc(1, 'h60, 11, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 'h50, 1, 0);
        check("bp.as_valid", 64'(as_valid), 1);
        check("bp.cache_resp_ready", 64'(cache_resp_ready), 0);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 0, 1, 'h60, 0, 0);
            check($sformatf("bp.hold%0d.as_entry", k), 64'(as_entry), 64'(ent(10, 'h50, 1)));
            check($sformatf("bp.hold%0d.occupancy", k), 64'(occupancy), 1);
        end
        cyc(0, 0, 0, 0, 1, 'h60, 0, 1);
        check("bp.second.as_valid", 64'(as_valid), 1);
        check("bp.second.as_entry", 64'(as_entry), 64'(ent(11, 'h60, 0)));
        check("bp.second.occupancy", 64'(occupancy), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        check("bp.drain.as_valid", 64'(as_valid), 0);

        // Unmatched response, then reset mid-flight.
        check("unm.before", 64'(unmatched_resp), 0);
        cyc(0, 0, 0, 0, 1, 'hDEAD, 1, 1);
        check("unm.flag", 64'(unmatched_resp), 1);
        check("unm.no_as_valid", 64'(as_valid), 0);
        cyc(1, 'h70, 12, 0, 0, 0, 0, 1);
        check("unm.occupancy", 64'(occupancy), 1);
        @(negedge clk);
        req_valid = 0; cache_req_ready = 1; cache_resp_valid = 1; cache_resp_addr = 'h70; as_ready = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset.outputs", {req_ready, cache_req_valid, cache_resp_ready, as_valid, unmatched_resp},
              5'b10100);
        check("midreset.occupancy", 64'(occupancy), 0);
        check("midreset.as_entry", 64'(as_entry), 0);
        cache_resp_valid = 0;
        reset_dut();

        // Randomized run against the allocation-order model.
        q.delete();
        n_alloc = 0; n_disp = 0; m_av = 0; m_unm = 0; m_ae = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            m_rr = 1;
            m_ca = '0;
            disp_list.delete();
            foreach (q[j]) begin
                if (q[j].seq == n_alloc - D) m_rr = 0;
                if (q[j].seq == n_disp) m_ca = q[j].addr;
                if (q[j].disp) disp_list.push_back(j);
            end
            m_cv = (n_disp < n_alloc);
            req_valid       = 1'($urandom_range(0, 1));
            req_addr        = AW'($urandom_range(0, 7) * 16);
            req_trace_index = IW'($urandom);
            cache_req_ready = 1'($urandom_range(0, 1));
            as_ready        = ($urandom_range(0, 3) != 0);
            cache_resp_hit  = 1'($urandom_range(0, 1));
            cache_resp_valid = 0;
            cache_resp_addr  = '0;
            if (disp_list.size() > 0 && $urandom_range(0, 2) != 0) begin
                cache_resp_valid = 1;
                cache_resp_addr  = q[disp_list[$urandom_range(0, disp_list.size() - 1)]].addr;
            end else if ($urandom_range(0, 31) == 0) begin
                cache_resp_valid = 1;
                cache_resp_addr  = 'hDEAD;
            end
            m_rsr = !m_av || as_ready;
            #1;
            check($sformatf("rand%0d.ctrl", c),
                  64'({req_ready, cache_req_valid, cache_req_valid ? cache_req_addr : AW'(0),
                       cache_resp_ready, as_valid, unmatched_resp, occupancy}),
                  64'({m_rr, m_cv, m_cv ? m_ca : AW'(0), m_rsr, m_av, m_unm, 3'(q.size())}));
            if (m_av)
                check($sformatf("rand%0d.as_entry", c), 64'(as_entry), 64'(m_ae));
            @(posedge clk);
            m_found = 0;
            if (cache_resp_valid && m_rsr) begin
                for (int j = 0; j < q.size(); j++) begin
                    if (!m_found && q[j].disp && q[j].addr == cache_resp_addr) begin
                        m_found = 1;
                        m_ae = {q[j].idx, q[j].addr, cache_resp_hit};
                        q.delete(j);
                    end
                end
                if (!m_found) m_unm = 1;
            end
            if (m_found) m_av = 1;
            else if (m_av && as_ready) m_av = 0;
            if (m_cv && cache_req_ready) begin
                for (int j = 0; j < q.size(); j++) begin
                    if (q[j].seq == n_disp) begin
                        tmp = q[j];
                        tmp.disp = 1;
                        q[j] = tmp;
                    end
                end
                n_disp++;
            end
            if (req_valid && m_rr) begin
                tmp.seq = n_alloc; tmp.addr = req_addr; tmp.idx = req_trace_index; tmp.disp = 0;
                q.push_back(tmp);
                n_alloc++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
